// File: rtl/rvc_asap_eot_monitor.sv
// End-of-test and retirement monitor for the rvc_asap instruction stream.
// Counts retired instructions and cycles; terminates on ebreak, hung PC or timeout.
module rvc_asap_eot_monitor #(
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned HANG_LIMIT     = 16,
   parameter int unsigned DRAIN_CYCLES   = 4
) (
   input  logic        Clock,
   input  logic        Rst,
   input  logic        InstValid,
   input  logic [31:0] Pc,
   input  logic [31:0] Instruction,
   output logic        Done,
   output logic        EotValid,
   output logic [1:0]  EotCause,
   output logic [31:0] EotPc,
   output logic [31:0] InstCount,
   output logic [31:0] CycleCount
);

   localparam int unsigned HANG_W  = $clog2(HANG_LIMIT + 1);
   localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);

   localparam logic [31:0]        EBREAK_C     = 32'h0010_0073;
   localparam logic [HANG_W-1:0]  HANG_LIM_C   = HANG_W'(HANG_LIMIT);
   localparam logic [DRAIN_W-1:0] DRAIN_INIT_C = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST_C = DRAIN_W'(1);
   localparam logic [31:0]        TO_LAST_C    = 32'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] CAUSE_NONE    = 2'd0;
   localparam logic [1:0] CAUSE_EBREAK  = 2'd1;
   localparam logic [1:0] CAUSE_HANG    = 2'd2;
   localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic                done_q, done_d;
   logic                eot_valid_q, eot_valid_d;
   logic [1:0]          cause_q, cause_d;
   logic [31:0]         eot_pc_q, eot_pc_d;
   logic [31:0]         inst_cnt_q, inst_cnt_d;
   logic [31:0]         cycle_cnt_q, cycle_cnt_d;
   logic [31:0]         last_pc_q, last_pc_d;
   logic [HANG_W-1:0]   hang_cnt_q, hang_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;

   logic                is_ebreak;
   logic                pc_repeat;
   logic                active_edge;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign is_ebreak   = InstValid && (Instruction == EBREAK_C);
   // In IDLE the instruction is the first after reset, so it can never be a repeat.
   assign pc_repeat   = InstValid && (state_q == RUN) && (Pc == last_pc_q);
   assign active_edge = (state_q == RUN) || ((state_q == IDLE) && InstValid);

   always_comb begin
      state_d     = state_q;
      done_d      = done_q;
      eot_valid_d = 1'b0;
      cause_d     = cause_q;
      eot_pc_d    = eot_pc_q;
      inst_cnt_d  = inst_cnt_q;
      cycle_cnt_d = cycle_cnt_q;
      last_pc_d   = last_pc_q;
      hang_cnt_d  = hang_cnt_q;
      drain_cnt_d = drain_cnt_q;

      case (state_q)
         IDLE, RUN: begin
            if (active_edge) begin
               state_d     = RUN;
               cycle_cnt_d = sat_inc(cycle_cnt_q);
               if (InstValid) begin
                  inst_cnt_d = sat_inc(inst_cnt_q);
                  last_pc_d  = Pc;
                  eot_pc_d   = Pc;
                  hang_cnt_d = pc_repeat ? hang_cnt_q + HANG_W'(1) : '0;
               end
               // ebreak outranks hang and timeout detected on the same edge.
               if (is_ebreak) begin
                  state_d     = DRAIN;
                  cause_d     = CAUSE_EBREAK;
                  drain_cnt_d = DRAIN_INIT_C;
               end else if (InstValid && (hang_cnt_d == HANG_LIM_C)) begin
                  state_d = DONE;
                  cause_d = CAUSE_HANG;
               end else if (cycle_cnt_q == TO_LAST_C) begin
                  state_d = DONE;
                  cause_d = CAUSE_TIMEOUT;
               end
            end
         end
         DRAIN: begin
            cycle_cnt_d = sat_inc(cycle_cnt_q);
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
            if (drain_cnt_q == DRAIN_LAST_C) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_d == DONE) && (state_q != DONE)) begin
         done_d      = 1'b1;
         eot_valid_d = 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Rst) begin
         state_q     <= IDLE;
         done_q      <= 1'b0;
         eot_valid_q <= 1'b0;
         cause_q     <= CAUSE_NONE;
         eot_pc_q    <= '0;
         inst_cnt_q  <= '0;
         cycle_cnt_q <= '0;
         last_pc_q   <= '0;
         hang_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         done_q      <= done_d;
         eot_valid_q <= eot_valid_d;
         cause_q     <= cause_d;
         eot_pc_q    <= eot_pc_d;
         inst_cnt_q  <= inst_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
         last_pc_q   <= last_pc_d;
         hang_cnt_q  <= hang_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign Done       = done_q;
   assign EotValid   = eot_valid_q;
   assign EotCause   = cause_q;
   assign EotPc      = eot_pc_q;
   assign InstCount  = inst_cnt_q;
   assign CycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_rvc_asap_eot_monitor.sv
// Directed bench for rvc_asap_eot_monitor: three instances differing only in TIMEOUT_CYCLES
// share one stimulus stream; each scenario checks the instance whose parameters it targets.
module tb_rvc_asap_eot_monitor;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] JSELF  = 32'h0000_006F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        inst_valid = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instr = '0;

   logic        m_done, m_ev, t_done, t_ev, s_done, s_ev;
   logic [1:0]  m_cause, t_cause, s_cause;
   logic [31:0] m_epc, m_ic, m_cc, t_epc, t_ic, t_cc, s_epc, s_ic, s_cc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rvc_asap_eot_monitor #(.TIMEOUT_CYCLES(1000), .HANG_LIMIT(16), .DRAIN_CYCLES(4)) u_main (
      .Clock(clk), .Rst(rst), .InstValid(inst_valid), .Pc(pc), .Instruction(instr),
      .Done(m_done), .EotValid(m_ev), .EotCause(m_cause), .EotPc(m_epc),
      .InstCount(m_ic), .CycleCount(m_cc));

   rvc_asap_eot_monitor #(.TIMEOUT_CYCLES(20), .HANG_LIMIT(16), .DRAIN_CYCLES(4)) u_to20 (
      .Clock(clk), .Rst(rst), .InstValid(inst_valid), .Pc(pc), .Instruction(instr),
      .Done(t_done), .EotValid(t_ev), .EotCause(t_cause), .EotPc(t_epc),
      .InstCount(t_ic), .CycleCount(t_cc));

   rvc_asap_eot_monitor #(.TIMEOUT_CYCLES(6), .HANG_LIMIT(16), .DRAIN_CYCLES(4)) u_to6 (
      .Clock(clk), .Rst(rst), .InstValid(inst_valid), .Pc(pc), .Instruction(instr),
      .Done(s_done), .EotValid(s_ev), .EotCause(s_cause), .EotPc(s_epc),
      .InstCount(s_ic), .CycleCount(s_cc));

   typedef struct {
      logic        vld;
      logic [31:0] pc;
      logic [31:0] ins;
      logic        done;
      logic        ev;
      logic [1:0]  cause;
      logic [31:0] epc;
      logic [31:0] ic;
      logic [31:0] cc;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input logic v, input logic [31:0] p, input logic [31:0] i,
                               input logic d, input logic e, input logic [1:0] c,
                               input logic [31:0] ep, input logic [31:0] ic, input logic [31:0] cc);
      vec_t r;
      r.vld = v; r.pc = p; r.ins = i; r.done = d; r.ev = e; r.cause = c;
      r.epc = ep; r.ic = ic; r.cc = cc;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_main(input string tag, input logic d, input logic e, input logic [1:0] c,
                           input logic [31:0] ep, input logic [31:0] ic, input logic [31:0] cc);
      chk({tag, ".Done"}, {31'd0, m_done}, {31'd0, d});
      chk({tag, ".EotValid"}, {31'd0, m_ev}, {31'd0, e});
      chk({tag, ".EotCause"}, {30'd0, m_cause}, {30'd0, c});
      chk({tag, ".EotPc"}, m_epc, ep);
      chk({tag, ".InstCount"}, m_ic, ic);
      chk({tag, ".CycleCount"}, m_cc, cc);
   endtask

   task automatic step(input logic r, input logic v, input logic [31:0] p, input logic [31:0] i);
      rst = r; inst_valid = v; pc = p; instr = i;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Normal ebreak stream: five nops then ebreak at Pc 20, drain, then junk.
      vecs[0]  = mk(1'b1, 32'd0,     NOP,    1'b0, 1'b0, 2'd0, 32'd0,  32'd1, 32'd1);
      vecs[1]  = mk(1'b1, 32'd4,     NOP,    1'b0, 1'b0, 2'd0, 32'd4,  32'd2, 32'd2);
      vecs[2]  = mk(1'b1, 32'd8,     NOP,    1'b0, 1'b0, 2'd0, 32'd8,  32'd3, 32'd3);
      vecs[3]  = mk(1'b1, 32'd12,    NOP,    1'b0, 1'b0, 2'd0, 32'd12, 32'd4, 32'd4);
      vecs[4]  = mk(1'b1, 32'd16,    NOP,    1'b0, 1'b0, 2'd0, 32'd16, 32'd5, 32'd5);
      vecs[5]  = mk(1'b1, 32'd20,    EBREAK, 1'b0, 1'b0, 2'd1, 32'd20, 32'd6, 32'd6);
      vecs[6]  = mk(1'b1, 32'h100,   NOP,    1'b0, 1'b0, 2'd1, 32'd20, 32'd6, 32'd7);
      vecs[7]  = mk(1'b0, 32'h104,   EBREAK, 1'b0, 1'b0, 2'd1, 32'd20, 32'd6, 32'd8);
      vecs[8]  = mk(1'b1, 32'h108,   JSELF,  1'b0, 1'b0, 2'd1, 32'd20, 32'd6, 32'd9);
      vecs[9]  = mk(1'b0, 32'h10C,   NOP,    1'b1, 1'b1, 2'd1, 32'd20, 32'd6, 32'd10);
      vecs[10] = mk(1'b1, 32'h110,   EBREAK, 1'b1, 1'b0, 2'd1, 32'd20, 32'd6, 32'd10);

      step(1'b1, 1'b0, 32'd0, 32'd0);
      step(1'b1, 1'b0, 32'd0, 32'd0);
      chk_main("reset", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      chk("reset.to6.Done", {31'd0, s_done}, 32'd0);

      for (int k = 0; k < 11; k++) begin
         step(1'b0, vecs[k].vld, vecs[k].pc, vecs[k].ins);
         chk_main($sformatf("ebreak[%0d]", k), vecs[k].done, vecs[k].ev, vecs[k].cause,
                  vecs[k].epc, vecs[k].ic, vecs[k].cc);
         // Same stream on TIMEOUT_CYCLES=6: ebreak lands on the timeout edge.
         if (k == 5 || k == 6) begin
            chk($sformatf("prio[%0d].Done", k), {31'd0, s_done}, 32'd0);
            chk($sformatf("prio[%0d].EotCause", k), {30'd0, s_cause}, 32'd1);
         end
         if (k == 9) begin
            chk("prio.Done", {31'd0, s_done}, 32'd1);
            chk("prio.EotCause", {30'd0, s_cause}, 32'd1);
            chk("prio.CycleCount", s_cc, 32'd10);
         end
      end

      // Hang: same Pc every edge; the 17th valid edge hits HANG_LIMIT.
      step(1'b1, 1'b0, 32'd0, 32'd0);
      for (int k = 1; k <= 17; k++) begin
         step(1'b0, 1'b1, 32'h40, JSELF);
         if (k == 16) chk("hang16.Done", {31'd0, m_done}, 32'd0);
      end
      chk_main("hang", 1'b1, 1'b1, 2'd2, 32'h40, 32'd17, 32'd17);
      step(1'b0, 1'b1, 32'h40, JSELF);
      chk("hang.EotValid_drop", {31'd0, m_ev}, 32'd0);

      // Hang with bubbles: valid on odd edges only.
      step(1'b1, 1'b0, 32'd0, 32'd0);
      for (int k = 1; k <= 33; k++) begin
         step(1'b0, (k % 2) == 1, 32'h40, JSELF);
         if (k == 32) chk("bubble32.Done", {31'd0, m_done}, 32'd0);
      end
      chk_main("bubble", 1'b1, 1'b1, 2'd2, 32'h40, 32'd17, 32'd33);

      // Timeout on TIMEOUT_CYCLES=20 with incrementing Pc.
      step(1'b1, 1'b0, 32'd0, 32'd0);
      for (int k = 1; k <= 20; k++) begin
         step(1'b0, 1'b1, 32'((k - 1) * 4), NOP);
         if (k == 19) chk("to19.Done", {31'd0, t_done}, 32'd0);
      end
      chk("timeout.Done", {31'd0, t_done}, 32'd1);
      chk("timeout.EotValid", {31'd0, t_ev}, 32'd1);
      chk("timeout.EotCause", {30'd0, t_cause}, 32'd3);
      chk("timeout.EotPc", t_epc, 32'd76);
      chk("timeout.InstCount", t_ic, 32'd20);
      chk("timeout.CycleCount", t_cc, 32'd20);

      // Reset during DRAIN, with an ebreak presented on the reset edge.
      step(1'b1, 1'b0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 32'h80, EBREAK);
      step(1'b0, 1'b0, 32'd0, 32'd0);
      chk_main("pre_rst_drain", 1'b0, 1'b0, 2'd1, 32'h80, 32'd1, 32'd2);
      step(1'b1, 1'b1, 32'h84, EBREAK);
      chk_main("rst_drain", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 32'h90, EBREAK);
      chk_main("idle_bubbles", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      step(1'b0, 1'b1, 32'h200, EBREAK);
      for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 32'd0);
      chk_main("post_rst", 1'b1, 1'b1, 2'd1, 32'h200, 32'd1, 32'd5);

      // DONE is absorbing: toggle inputs, nothing moves.
      for (int k = 0; k < 5; k++) begin
         step(1'b0, k[0], 32'h300 + 32'(k * 4), (k % 2 == 0) ? EBREAK : JSELF);
         chk_main($sformatf("done_hold[%0d]", k), 1'b1, 1'b0, 2'd1, 32'h200, 32'd1, 32'd5);
      end

      step(1'b1, 1'b0, 32'd0, 32'd0);
      chk_main("final_rst", 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rvc_asap_eot_monitor.md
# rvc_asap_eot_monitor

End-of-test and retirement monitor for the rvc_asap core, sitting directly downstream of the core's fetch/decode instruction stream. It samples every valid `Pc`/`Instruction` pair and counts retired instructions and elapsed cycles. It declares end-of-test on an `ebreak`, on a hung PC, or on a cycle timeout. The result is presented as a registered `Done` level plus a cause code, so the bench or an FPGA wrapper no longer needs XMR polling of the core.

## Interface
- `TIMEOUT_CYCLES`, default 1000: cycle budget counted from the first valid instruction; must be ≥2.
- `HANG_LIMIT`, default 16: consecutive repeats of the same valid `Pc` that declare a hang; must be ≥1.
- `DRAIN_CYCLES`, default 4: cycles waited after `ebreak` so in-flight writebacks complete; must be ≥1.
- `Clock` input, 1: single clock. All logic updates on the rising edge.
- `Rst` input, 1: synchronous, active-high reset.
- `InstValid` input, 1: `Pc` and `Instruction` are valid this cycle.
- `Pc` input, 32: PC of the current instruction.
- `Instruction` input, 32: current instruction word.
- `Done` output, 1: level. High from entry into DONE until reset.
- `EotValid` output, 1: single-cycle pulse in the first cycle `Done` is high.
- `EotCause` output, 2: 0 = none, 1 = ebreak, 2 = hang, 3 = timeout.
- `EotPc` output, 32: `Pc` of the terminating instruction. For timeout, the last valid `Pc`.
- `InstCount` output, 32: number of valid instructions accepted.
- `CycleCount` output, 32: number of edges counted in the active window.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset forces IDLE.
- Reset values:
  - `Done`, `EotValid`, `EotCause`, `EotPc`, `InstCount` and `CycleCount` are all 0.
  - Internal `LastPc` is 0, `HangCnt` is 0 and `DrainCnt` is 0.
- An edge with `InstValid` = 0 in IDLE or RUN changes nothing except `CycleCount` (RUN only). It neither increments nor clears `HangCnt`.
- **IDLE:** the first edge with `InstValid` = 1 behaves as a RUN edge, including the ebreak check, and leaves IDLE.
- **RUN**, on each accepted edge:
  - `CycleCount` increments.
  - If `InstValid` is high, `InstCount` increments and `LastPc`/`EotPc` load `Pc`.
  - Hang tracking:
    - A valid `Pc` equal to `LastPc` increments `HangCnt`.
    - A different `Pc` clears it.
    - The first valid instruction after reset never counts as a repeat.
- **Termination checks**, evaluated on the same edge in this priority order:
  - **ebreak:** `InstValid` is high and `Instruction` = 32'h00100073. Go to DRAIN, set `EotCause` = 1, load `DrainCnt` = `DRAIN_CYCLES`.
  - **hang:** the post-increment `HangCnt` equals `HANG_LIMIT`. Go to DONE with `EotCause` = 2.
  - **timeout:** the pre-edge `CycleCount` equals `TIMEOUT_CYCLES`-1. Go to DONE with `EotCause` = 3.
- **DRAIN:**
  - `CycleCount` increments each edge and `DrainCnt` decrements.
  - `InstCount` and `EotPc` are frozen, and `InstValid`/`Instruction` are ignored.
  - Timeout and hang checks are disabled.
  - The edge where pre-edge `DrainCnt` = 1 moves the block to DONE.
- **DONE:**
  - Absorbing state. All counters and outputs are frozen and inputs are ignored.
  - Only `Rst` leaves DONE.
- **Arithmetic:**
  - `InstCount` and `CycleCount` saturate at 32'hFFFFFFFF and never wrap.
  - `HangCnt` is sized to hold `HANG_LIMIT`.
  - `DrainCnt` is sized to hold `DRAIN_CYCLES`.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Latency from an ebreak edge E to `Done` visible: `Done` rises after edge E+`DRAIN_CYCLES`. Final `CycleCount` = RUN edges + `DRAIN_CYCLES`.
- Latency for hang or timeout: `Done` rises after the detecting edge, with 1 cycle of latency.
- `EotValid` is high for exactly the one cycle after the DONE-entry edge, then stays low until reset.
- `Rst` high at any edge, including mid-DRAIN or in DONE, returns every output to its reset value after that edge. `Rst` dominates all other conditions.
- An ebreak at a repeated `Pc` on the edge that would also hit `HANG_LIMIT` or the timeout resolves as ebreak (cause 1).

## Test plan
- **Normal ebreak:** `DRAIN_CYCLES`=4. Send valid 0x00000013 at `Pc` 0,4,8,12,16, then 0x00100073 at `Pc` 20, on consecutive edges. Expected result:
  - `Done`/`EotValid` rise 4 edges after the ebreak edge.
  - `EotCause`=1, `EotPc`=20, `InstCount`=6, `CycleCount`=10.
  - `EotValid` is high for exactly 1 cycle.
- **Hang:** `HANG_LIMIT`=16. Send `Pc`=0x40 with `Instruction`=0x0000006F, valid every edge. Expected: `Done` after the 17th valid edge, `EotCause`=2, `EotPc`=0x40, `InstCount`=17.
- **Hang with bubbles:** the same stream with `InstValid` low every other edge. Expected: still terminates after the 17th valid instruction, with `CycleCount`=33.
- **Timeout:** `TIMEOUT_CYCLES`=20. Send `Pc` incrementing by 4 with nops, never ebreak. Expected: `Done` after edge 20, `EotCause`=3, `CycleCount`=20, `InstCount`=20.
- **Priority:** `TIMEOUT_CYCLES`=6. Send ebreak exactly on the 6th edge. Expected: `EotCause`=1, entry into DRAIN, no timeout.
- **Reset mid-operation:**
  - Assert `Rst` for 1 edge during DRAIN. Expected: all outputs 0, state IDLE, and a subsequent ebreak-only stream ends with `InstCount`=1.
  - Inputs toggled while in DONE. Expected: no change to any output.
